// File: rtl/maxpool_2x2_unit_if.sv
// Stream bundle between the conv engine, the 2x2 max-pool stage and its consumer.
`timescale 1ns/1ps
interface maxpool_2x2_unit_if #(
  parameter int DATA_W = 16
) ();
  logic                     conv_valid_i;
  logic signed [DATA_W-1:0] conv_data_i;
  logic                     pool_valid_o;
  logic signed [DATA_W-1:0] pool_data_o;
  logic                     pooling_finish;

  modport master (
    output conv_valid_i, conv_data_i,
    input  pool_valid_o, pool_data_o, pooling_finish
  );

  modport slave (
    input  conv_valid_i, conv_data_i,
    output pool_valid_o, pool_data_o, pooling_finish
  );
endinterface

// File: rtl/maxpool_2x2_unit.sv
// 2x2 stride-2 signed max-pool over a raster-order conv feature map.
//   state  | meaning
//   IDLE   | waiting for pooling_ctrl; beats ignored
//   ACTIVE | accepting pixels, counting col/row
//   DONE   | one cycle, final pooled pixel and pooling_finish out
`timescale 1ns/1ps
module maxpool_2x2_unit #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           pooling_ctrl,
  maxpool_2x2_unit_if.slave pif
);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB  = IMG_W / 2;
  localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

  generate
    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_w
      $error("maxpool_2x2_unit: IMG_W must be even");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_h
      $error("maxpool_2x2_unit: IMG_H must be even");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic                     pv_q, pv_d;
  logic signed [DATA_W-1:0] pd_q, pd_d;
  logic signed [DATA_W-1:0] lbuf_q [LB];
  logic                     lb_we;
  logic [LBW-1:0]           lb_idx;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] hmax;

  assign lb_idx = LBW'(col_q >> 1);
  assign lb_rd  = lbuf_q[lb_idx];
  assign hmax   = (hold_q > pif.conv_data_i) ? hold_q : pif.conv_data_i;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    pv_d    = 1'b0;
    pd_d    = pd_q;
    lb_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        if (pooling_ctrl) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!pooling_ctrl) begin
          // abort: drop the partial frame, nothing more is emitted
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else if (pif.conv_valid_i) begin
          if (!col_q[0]) begin
            hold_d = pif.conv_data_i;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            pv_d = 1'b1;
            pd_d = (lb_rd > hmax) ? lb_rd : hmax;
          end
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_H - 1)) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
    end
  end

  // line buffer holds even-row horizontal maxima; contents need no reset
  always_ff @(posedge clk) begin
    if (lb_we) lbuf_q[lb_idx] <= hmax;
  end

  assign pif.pool_valid_o   = pv_q;
  assign pif.pool_data_o    = pd_q;
  assign pif.pooling_finish = (state_q == DONE);
endmodule

// File: tb/tb_maxpool_2x2_unit.sv
// Directed bench for maxpool_2x2_unit: 4x4 instance for window/latency/abort/reset cases,
// 28x28 instance for back-to-back full frames.
`timescale 1ns/1ps
module tb_maxpool_2x2_unit;
  logic clk = 1'b0;
  logic nrst;
  logic ctrl4, ctrl28;

  always #5 clk = ~clk;

  maxpool_2x2_unit_if #(.DATA_W(16)) if4  ();
  maxpool_2x2_unit_if #(.DATA_W(16)) if28 ();

  maxpool_2x2_unit #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .pooling_ctrl(ctrl4), .pif(if4.slave)
  );

  maxpool_2x2_unit #(.DATA_W(16), .IMG_W(28), .IMG_H(28)) u_dut28 (
    .clk(clk), .nrst(nrst), .pooling_ctrl(ctrl28), .pif(if28.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  int o4_dat[$];
  int o4_cyc[$];
  int f4_cyc[$];
  int o28_dat[$];
  int f28_n   = 0;
  int f28_bad = 0;

  always @(negedge clk) begin
    if (if4.pool_valid_o) begin
      o4_dat.push_back(int'(if4.pool_data_o));
      o4_cyc.push_back(cyc);
    end
    if (if4.pooling_finish) f4_cyc.push_back(cyc);
    if (if28.pool_valid_o) o28_dat.push_back(int'(if28.pool_data_o));
    if (if28.pooling_finish) begin
      f28_n <= f28_n + 1;
      if (!if28.pool_valid_o) f28_bad <= f28_bad + 1;
    end
  end

  int beat_cyc[16];
  int closer[4] = '{5, 7, 13, 15};
  int d_ramp[16];
  int e_ramp[4] = '{5, 7, 13, 15};
  int d_sgn[16] = '{   -3,   -8, -32768, -32768,
                       -1,   -7, -32768, -32768,
                      100, -100,     -5,     -2,
                    32767,    0,     -9,     -4};
  int e_sgn[4]  = '{-1, -32768, 32767, -2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4();
    ctrl4 = 1'b1;
    tick();
  endtask

  task automatic clear4();
    o4_dat.delete();
    o4_cyc.delete();
    f4_cyc.delete();
  endtask

  task automatic drive_frame4(input int d[16], input bit gaps, input int n_beats);
    for (int i = 0; i < n_beats; i++) begin
      if (gaps) begin
        if4.conv_valid_i = 1'b0;
        if4.conv_data_i  = 16'sh7fff;
        tick();
      end
      if4.conv_valid_i = 1'b1;
      if4.conv_data_i  = 16'(d[i]);
      beat_cyc[i] = cyc;
      tick();
    end
    if4.conv_valid_i = 1'b0;
    if4.conv_data_i  = '0;
  endtask

  task automatic check_frame4(input string tag, input int e[4]);
    check({tag, " n_out"}, o4_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s out%0d data", tag, i), (i < o4_dat.size()) ? o4_dat[i] : -99999, e[i]);
      check($sformatf("%s out%0d latency", tag, i),
            (i < o4_cyc.size()) ? o4_cyc[i] - beat_cyc[closer[i]] : -1, 1);
    end
    check({tag, " n_finish"}, f4_cyc.size(), 1);
    check({tag, " finish_align"},
          (f4_cyc.size() > 0 && o4_cyc.size() == 4) ? f4_cyc[0] - o4_cyc[3] : -1, 0);
    clear4();
  endtask

  task automatic finish_frame4();
    repeat (3) tick();
    ctrl4 = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) d_ramp[i] = i;
    nrst = 1'b0;
    ctrl4 = 1'b0;
    ctrl28 = 1'b0;
    if4.conv_valid_i  = 1'b0;
    if4.conv_data_i   = '0;
    if28.conv_valid_i = 1'b0;
    if28.conv_data_i  = '0;
    #1;
    check("reset valid",  int'(if4.pool_valid_o), 0);
    check("reset data",   int'(if4.pool_data_o), 0);
    check("reset finish", int'(if4.pooling_finish), 0);
    repeat (2) tick();
    nrst = 1'b1;
    tick();

    // ramp, continuous valid
    start4();
    drive_frame4(d_ramp, 1'b0, 16);
    finish_frame4();
    check_frame4("t1", e_ramp);

    // signed windows
    start4();
    drive_frame4(d_sgn, 1'b0, 16);
    finish_frame4();
    check_frame4("t2", e_sgn);

    // valid gaps every other cycle
    start4();
    drive_frame4(d_ramp, 1'b1, 16);
    finish_frame4();
    check_frame4("t3", e_ramp);

    // abort after beat 9, remaining beats presented with ctrl low
    start4();
    drive_frame4(d_ramp, 1'b0, 10);
    ctrl4 = 1'b0;
    for (int i = 10; i < 16; i++) begin
      if4.conv_valid_i = 1'b1;
      if4.conv_data_i  = 16'(i);
      tick();
    end
    if4.conv_valid_i = 1'b0;
    repeat (3) tick();
    check("t4 n_out", o4_dat.size(), 2);
    check("t4 out0", (o4_dat.size() > 0) ? o4_dat[0] : -99999, 5);
    check("t4 out1", (o4_dat.size() > 1) ? o4_dat[1] : -99999, 7);
    check("t4 n_finish", f4_cyc.size(), 0);
    clear4();
    start4();
    drive_frame4(d_ramp, 1'b0, 16);
    finish_frame4();
    check_frame4("t4 refill", e_ramp);

    // async reset while beat 6 is on the bus, output 5 currently shown
    start4();
    drive_frame4(d_ramp, 1'b0, 6);
    if4.conv_valid_i = 1'b1;
    if4.conv_data_i  = 16'sd6;
    #1;
    check("t5 pre-reset data", int'(if4.pool_data_o), 5);
    #1;
    nrst = 1'b0;
    #1;
    check("t5 async valid",  int'(if4.pool_valid_o), 0);
    check("t5 async data",   int'(if4.pool_data_o), 0);
    check("t5 async finish", int'(if4.pooling_finish), 0);
    if4.conv_valid_i = 1'b0;
    ctrl4 = 1'b0;
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    clear4();
    start4();
    drive_frame4(d_ramp, 1'b0, 16);
    finish_frame4();
    check_frame4("t5 after reset", e_ramp);

    // 28x28 back-to-back frames, two junk beats land in DONE/IDLE between them
    ctrl28 = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 28; r++) begin
        for (int c = 0; c < 28; c++) begin
          if28.conv_valid_i = 1'b1;
          if28.conv_data_i  = 16'((f == 0) ? (r * 28 + c) : -(r * 28 + c));
          tick();
        end
      end
      if (f == 0) begin
        repeat (2) begin
          if28.conv_data_i = 16'sh7fff;
          tick();
        end
      end
    end
    if28.conv_valid_i = 1'b0;
    repeat (5) tick();
    ctrl28 = 1'b0;
    tick();
    check("t6 n_out", o28_dat.size(), 392);
    check("t6 n_finish", f28_n, 2);
    check("t6 finish without valid", f28_bad, 0);
    for (int k = 0; k < 392; k++) begin
      int i, j, e;
      i = (k % 196) / 14;
      j = (k % 196) % 14;
      e = (k < 196) ? ((2 * i + 1) * 28 + 2 * j + 1) : -(2 * i * 28 + 2 * j);
      check($sformatf("t6 out%0d", k), (k < o28_dat.size()) ? o28_dat[k] : -99999, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
